// File: rtl/sprite_lane_spawner_pkg.sv
// sprite_lane_spawner_pkg: shared screen geometry, spawner defaults and spawn-decision encoding.
// Rev 1.0
`default_nettype none

package sprite_lane_spawner_pkg;

  localparam int WINDOW_WIDTH  = 640;
  localparam int WINDOW_HEIGHT = 480;

  localparam int DEF_NUM_SLOTS       = 3;
  localparam int DEF_SPRITE_W        = 52;
  localparam int DEF_SPRITE_H        = 19;
  localparam int DEF_SPAWN_X         = WINDOW_WIDTH + DEF_SPRITE_W;
  localparam int DEF_Y_BASE          = 240;
  localparam int DEF_RAND_W          = 7;
  localparam int DEF_GAP_MIN         = 200;
  localparam int DEF_GAP_FULL_RELOAD = 50;
  localparam int DEF_GAP_SKIP_RELOAD = 80;
  localparam int DEF_SKIP_THRESH     = 10;
  localparam int DEF_STEP            = 1;
  localparam int DEF_XW              = 11;
  localparam int DEF_ADDR_W          = 17;

  localparam int SLOT_IDX_W = 3;

  typedef enum logic [1:0] {
    SPAWN_COUNT = 2'd0,
    SPAWN_FULL  = 2'd1,
    SPAWN_SKIP  = 2'd2,
    SPAWN_LOAD  = 2'd3
  } spawn_act_e;

  function automatic int gap_width(input int gap_min);
    return (gap_min < 1) ? 1 : $clog2(gap_min + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_lane_spawner_slot.sv
// sprite_lane_spawner_slot: one sprite's enable/position state plus its per-pixel hit test.
// Rev 1.0
`default_nettype none

module sprite_lane_spawner_slot
  import sprite_lane_spawner_pkg::*;
#(
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H,
  parameter int SPAWN_X  = DEF_SPAWN_X,
  parameter int STEP     = DEF_STEP,
  parameter int XW       = DEF_XW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [XW-1:0] load_y_i,
  input  logic          step_en_i,
  input  logic [9:0]    h_cnt_i,
  input  logic [9:0]    v_cnt_i,
  output logic          en_o,
  output logic          hit_o,
  output logic [XW:0]   col_o,
  output logic [XW:0]   row_o
);

  localparam int EW = XW + 1;

  logic          en_q, en_d;
  logic [XW-1:0] xpos_q, xpos_d;
  logic [XW-1:0] ypos_q, ypos_d;

  // A load only ever targets a slot that was idle, so it never collides with a move.
  always_comb begin
    en_d   = en_q;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    if (load_i) begin
      en_d   = 1'b1;
      xpos_d = XW'(SPAWN_X);
      ypos_d = load_y_i;
    end else if (step_en_i && en_q) begin
      if (xpos_q == '0) begin
        en_d = 1'b0;
      end else if (xpos_q < XW'(STEP)) begin
        xpos_d = '0;
      end else begin
        xpos_d = xpos_q - XW'(STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      xpos_q <= '0;
      ypos_q <= '0;
    end else if (clear_i) begin
      en_q   <= 1'b0;
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      en_q   <= en_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
    end
  end

  // One extra bit so h_cnt+SPRITE_W never wraps against the position.
  logic [EW-1:0] h_e, v_e, x_e, y_e, w_e, hgt_e;

  assign h_e   = EW'(h_cnt_i);
  assign v_e   = EW'(v_cnt_i);
  assign x_e   = {1'b0, xpos_q};
  assign y_e   = {1'b0, ypos_q};
  assign w_e   = EW'(SPRITE_W);
  assign hgt_e = EW'(SPRITE_H);

  assign en_o  = en_q;
  assign hit_o = en_q && (h_e < x_e) && ((h_e + w_e) >= x_e)
                      && (v_e < y_e) && ((v_e + hgt_e) >= y_e);
  assign col_o = h_e + w_e - x_e;
  assign row_o = v_e + hgt_e - y_e;

endmodule

`default_nettype wire

// File: rtl/sprite_lane_spawner.sv
// sprite_lane_spawner: N-slot background sprite spawner/scroller with registered per-pixel ROM addressing.
// Rev 1.0
`default_nettype none

module sprite_lane_spawner
  import sprite_lane_spawner_pkg::*;
#(
  parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
  parameter int SPRITE_W        = DEF_SPRITE_W,
  parameter int SPRITE_H        = DEF_SPRITE_H,
  parameter int SPAWN_X         = DEF_SPAWN_X,
  parameter int Y_BASE          = DEF_Y_BASE,
  parameter int RAND_W          = DEF_RAND_W,
  parameter int GAP_MIN         = DEF_GAP_MIN,
  parameter int GAP_FULL_RELOAD = DEF_GAP_FULL_RELOAD,
  parameter int GAP_SKIP_RELOAD = DEF_GAP_SKIP_RELOAD,
  parameter int SKIP_THRESH     = DEF_SKIP_THRESH,
  parameter int STEP            = DEF_STEP,
  parameter int XW              = DEF_XW,
  parameter int ADDR_W          = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  clear,
  input  logic [RAND_W-1:0]     rand_val,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  output logic                  pix_hit,
  output logic [SLOT_IDX_W-1:0] pix_slot,
  output logic [ADDR_W-1:0]     pix_addr,
  output logic [NUM_SLOTS-1:0]  slot_en
);

  localparam int GAP_W = gap_width(GAP_MIN);

  logic                 step;
  logic [NUM_SLOTS-1:0] en, hit, load, free_oh;
  logic [XW:0]          col [NUM_SLOTS];
  logic [XW:0]          row [NUM_SLOTS];
  logic [XW-1:0]        load_y;
  logic [GAP_W-1:0]     gap_q, gap_d;
  spawn_act_e           act;

  assign step   = tick && run;
  assign load_y = XW'(Y_BASE) - XW'(rand_val);

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      sprite_lane_spawner_slot #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .SPAWN_X  (SPAWN_X),
        .STEP     (STEP),
        .XW       (XW)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .load_i    (load[i]),
        .load_y_i  (load_y),
        .step_en_i (step),
        .h_cnt_i   (h_cnt),
        .v_cnt_i   (v_cnt),
        .en_o      (en[i]),
        .hit_o     (hit[i]),
        .col_o     (col[i]),
        .row_o     (row[i])
      );
    end
  endgenerate

  always_comb begin
    logic found;
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!en[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Every spawn decision looks only at pre-tick enables, so a slot retiring this tick stays unavailable.
  always_comb begin
    act = SPAWN_COUNT;
    if (gap_q < GAP_W'(GAP_MIN)) begin
      act = SPAWN_COUNT;
    end else if (&en) begin
      act = SPAWN_FULL;
    end else if (rand_val < RAND_W'(SKIP_THRESH)) begin
      act = SPAWN_SKIP;
    end else begin
      act = SPAWN_LOAD;
    end
  end

  always_comb begin
    gap_d = gap_q;
    load  = '0;
    if (step) begin
      case (act)
        SPAWN_COUNT: gap_d = gap_q + GAP_W'(1);
        SPAWN_FULL:  gap_d = GAP_W'(GAP_FULL_RELOAD);
        SPAWN_SKIP:  gap_d = GAP_W'(GAP_SKIP_RELOAD);
        SPAWN_LOAD: begin
          gap_d = '0;
          load  = free_oh;
        end
        default:     gap_d = gap_q;
      endcase
    end
  end

  logic                  w_hit;
  logic [SLOT_IDX_W-1:0] w_slot;
  logic [XW:0]           w_col, w_row;
  logic [ADDR_W-1:0]     w_addr;

  always_comb begin
    w_hit  = 1'b0;
    w_slot = '0;
    w_col  = '0;
    w_row  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        w_hit  = 1'b1;
        w_slot = SLOT_IDX_W'(i);
        w_col  = col[i];
        w_row  = row[i];
      end
    end
  end

  assign w_addr = w_hit ? (ADDR_W'(w_row) * ADDR_W'(SPRITE_W) + ADDR_W'(w_col)) : '0;

  logic                  pix_hit_q;
  logic [SLOT_IDX_W-1:0] pix_slot_q;
  logic [ADDR_W-1:0]     pix_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q      <= '0;
      pix_hit_q  <= 1'b0;
      pix_slot_q <= '0;
      pix_addr_q <= '0;
    end else if (clear) begin
      gap_q      <= '0;
      pix_hit_q  <= 1'b0;
      pix_slot_q <= '0;
      pix_addr_q <= '0;
    end else begin
      gap_q      <= gap_d;
      pix_hit_q  <= w_hit;
      pix_slot_q <= w_slot;
      pix_addr_q <= w_addr;
    end
  end

  assign pix_hit  = pix_hit_q;
  assign pix_slot = pix_slot_q;
  assign pix_addr = pix_addr_q;
  assign slot_en  = en;

endmodule

`default_nettype wire

// File: tb/tb_sprite_lane_spawner.sv
// tb_sprite_lane_spawner: randomized and directed checks of the sprite lane spawner against a behavioural model.
`default_nettype none

module tb_sprite_lane_spawner;

  localparam int NS    = 3;
  localparam int SW    = 52;
  localparam int SH    = 19;
  localparam int SX    = 692;
  localparam int YB    = 240;
  localparam int GMIN  = 200;
  localparam int GFULL = 50;
  localparam int GSKIP = 80;
  localparam int SKT   = 10;

  logic        clk = 1'b0;
  logic        rst, tick, run, clear;
  logic [6:0]  rand_val;
  logic [9:0]  h_cnt, v_cnt;
  logic        pix_hit, pix_hit2;
  logic [2:0]  pix_slot, pix_slot2;
  logic [16:0] pix_addr, pix_addr2;
  logic [2:0]  slot_en, slot_en2;

  always #5 clk = ~clk;

  sprite_lane_spawner u_dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear),
    .rand_val(rand_val), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pix_hit(pix_hit), .pix_slot(pix_slot), .pix_addr(pix_addr), .slot_en(slot_en)
  );

  // Short spawn gap so two sprites can overlap on screen.
  sprite_lane_spawner #(.GAP_MIN(10)) u_ovl (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear),
    .rand_val(rand_val), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pix_hit(pix_hit2), .pix_slot(pix_slot2), .pix_addr(pix_addr2), .slot_en(slot_en2)
  );

  int errors = 0;
  int checks = 0;

  int m_en [NS];
  int m_x  [NS];
  int m_y  [NS];
  int m_gap;

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_en[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_gap = 0;
  endtask

  task automatic model_tick(input int rv);
    int free_i;
    int spawn_i;
    bit all_busy;
    free_i = -1; spawn_i = -1; all_busy = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] == 0) begin
        all_busy = 1'b0;
        if (free_i < 0) free_i = i;
      end
    end
    if (m_gap < GMIN) m_gap = m_gap + 1;
    else if (all_busy) m_gap = GFULL;
    else if (rv < SKT) m_gap = GSKIP;
    else begin
      spawn_i = free_i;
      m_gap = 0;
    end
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] != 0) begin
        if (m_x[i] == 0) m_en[i] = 0;
        else m_x[i] = (m_x[i] > 1) ? m_x[i] - 1 : 0;
      end
    end
    if (spawn_i >= 0) begin
      m_en[spawn_i] = 1;
      m_x[spawn_i]  = SX;
      m_y[spawn_i]  = (YB - rv + 2048) % 2048;
    end
  endtask

  function automatic logic [2:0] model_en();
    logic [2:0] e;
    for (int i = 0; i < NS; i++) e[i] = (m_en[i] != 0);
    return e;
  endfunction

  function automatic logic [20:0] model_pix(input int h, input int v);
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] != 0 && h < m_x[i] && h + SW >= m_x[i] && v < m_y[i] && v + SH >= m_y[i])
        return {1'b1, 3'(i), 17'((v + SH - m_y[i]) * SW + (h + SW - m_x[i]))};
    end
    return 21'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int rv);
    tick = 1'b1;
    rand_val = 7'(rv);
    cyc();
    tick = 1'b0;
    if (run) model_tick(rv);
  endtask

  task automatic probe(input int h, input int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b0; run = 1'b0; clear = 1'b0;
    rand_val = '0; h_cnt = '0; v_cnt = '0;
    model_clear();
    repeat (3) cyc();
    checks++;
    if ({pix_hit, pix_slot, pix_addr, slot_en} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got hit=%0d slot=%0d addr=%0d en=%b, expected all zero",
               pix_hit, pix_slot, pix_addr, slot_en);
    end
    @(negedge clk);
    rst = 1'b1;
    probe(0, 0);
    checks++;
    if (slot_en !== 3'b000 || pix_hit !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got en=%b hit=%0d, expected en=000 hit=0", slot_en, pix_hit);
    end
  endtask

  task automatic test_first_spawn();
    run = 1'b1;
    for (int i = 1; i <= 201; i++) begin
      do_tick(20);
      if (i == 200 || i == 201) begin
        checks++;
        if (slot_en !== ((i == 201) ? 3'b001 : 3'b000)) begin
          errors++;
          $display("FAIL first_spawn tick %0d: got en=%b, expected %b", i, slot_en,
                   (i == 201) ? 3'b001 : 3'b000);
        end
      end
    end
    probe(680, 210);
    checks++;
    if ({pix_hit, pix_slot, pix_addr} !== {1'b1, 3'd0, 17'd508}) begin
      errors++;
      $display("FAIL spawn_position: got hit=%0d slot=%0d addr=%0d, expected 1/0/508",
               pix_hit, pix_slot, pix_addr);
    end
  endtask

  task automatic test_scroll();
    logic [2:0] exp_en;
    for (int i = 1; i <= 760; i++) begin
      do_tick(20);
      exp_en = {1'(i >= 402), 1'(i >= 201), 1'((i < 693) || (i >= 754))};
      checks++;
      if (slot_en !== exp_en) begin
        errors++;
        $display("FAIL scroll tick %0d: got en=%b, expected %b", i, slot_en, exp_en);
      end
      if (i == 691 || i == 692) begin
        probe(0, 210);
        checks++;
        if (pix_addr !== ((i == 691) ? 17'd519 : 17'd0) || pix_hit !== 1'(i == 691)) begin
          errors++;
          $display("FAIL left_edge tick %0d: got hit=%0d addr=%0d, expected hit=%0d addr=%0d",
                   i, pix_hit, pix_addr, (i == 691), (i == 691) ? 519 : 0);
        end
      end
    end
  endtask

  task automatic test_skip();
    do_clear();
    repeat (200) do_tick(20);
    do_tick(5);
    checks++;
    if (slot_en !== 3'b000) begin
      errors++;
      $display("FAIL skip_attempt: got en=%b, expected 000", slot_en);
    end
    repeat (120) do_tick(20);
    checks++;
    if (slot_en !== 3'b000) begin
      errors++;
      $display("FAIL skip_reload_early: got en=%b, expected 000", slot_en);
    end
    do_tick(20);
    checks++;
    if (slot_en !== 3'b001) begin
      errors++;
      $display("FAIL skip_reload_spawn: got en=%b, expected 001", slot_en);
    end
  endtask

  task automatic test_hit_and_freeze();
    do_clear();
    repeat (201) do_tick(20);
    repeat (592) do_tick(5);
    probe(60, 210);
    checks++;
    if ({pix_hit, pix_slot, pix_addr} !== {1'b1, 3'd0, 17'd480}) begin
      errors++;
      $display("FAIL hit_example: got hit=%0d slot=%0d addr=%0d, expected 1/0/480",
               pix_hit, pix_slot, pix_addr);
    end
    probe(100, 210);
    checks++;
    if ({pix_hit, pix_slot, pix_addr} !== 21'd0) begin
      errors++;
      $display("FAIL hit_right_edge: got hit=%0d slot=%0d addr=%0d, expected 0/0/0",
               pix_hit, pix_slot, pix_addr);
    end
    run = 1'b0;
    repeat (500) do_tick(20);
    probe(60, 210);
    checks++;
    if ({pix_hit, pix_slot, pix_addr, slot_en} !== {1'b1, 3'd0, 17'd480, 3'b001}) begin
      errors++;
      $display("FAIL freeze: got hit=%0d addr=%0d en=%b, expected 1/480/001", pix_hit, pix_addr, slot_en);
    end
    run = 1'b1;
    do_tick(20);
    probe(60, 210);
    checks++;
    if (pix_addr !== 17'd481) begin
      errors++;
      $display("FAIL resume_move: got addr=%0d, expected 481", pix_addr);
    end
    repeat (91) do_tick(20);
    checks++;
    if (slot_en !== 3'b001) begin
      errors++;
      $display("FAIL freeze_gap_hold: got en=%b, expected 001", slot_en);
    end
    do_tick(20);
    checks++;
    if (slot_en !== 3'b011) begin
      errors++;
      $display("FAIL freeze_gap_spawn: got en=%b, expected 011", slot_en);
    end
  endtask

  task automatic test_overlap();
    do_clear();
    run = 1'b1;
    repeat (22) do_tick(20);
    checks++;
    if (slot_en2 !== 3'b011) begin
      errors++;
      $display("FAIL overlap_spawn: got en=%b, expected 011", slot_en2);
    end
    probe(660, 210);
    checks++;
    if ({pix_hit2, pix_slot2, pix_addr2} !== {1'b1, 3'd0, 17'd499}) begin
      errors++;
      $display("FAIL overlap_priority: got hit=%0d slot=%0d addr=%0d, expected 1/0/499",
               pix_hit2, pix_slot2, pix_addr2);
    end
    probe(685, 210);
    checks++;
    if ({pix_hit2, pix_slot2, pix_addr2} !== {1'b1, 3'd1, 17'd513}) begin
      errors++;
      $display("FAIL overlap_second: got hit=%0d slot=%0d addr=%0d, expected 1/1/513",
               pix_hit2, pix_slot2, pix_addr2);
    end
  endtask

  task automatic test_random();
    int h, v, k;
    logic [20:0] exp_pix;
    do_clear();
    run = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      if (run && $urandom_range(0, 199) == 0) run = 1'b0;
      else if (!run && $urandom_range(0, 19) == 0) run = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        do_tick(int'($urandom_range(0, 127)));
        checks++;
        if (slot_en !== model_en()) begin
          errors++;
          $display("FAIL random_en step %0d: got %b, expected %b", n, slot_en, model_en());
        end
      end else begin
        k = int'($urandom_range(0, NS - 1));
        if (m_en[k] != 0 && $urandom_range(0, 3) != 0) begin
          h = m_x[k] - int'($urandom_range(0, SW + 4));
          v = m_y[k] - int'($urandom_range(0, SH + 3));
        end else begin
          h = int'($urandom_range(0, 1023));
          v = int'($urandom_range(0, 479));
        end
        if (h < 0 || h > 1023) h = int'($urandom_range(0, 1023));
        if (v < 0 || v > 1023) v = int'($urandom_range(0, 479));
        probe(h, v);
        exp_pix = model_pix(h, v);
        checks++;
        if ({pix_hit, pix_slot, pix_addr} !== exp_pix) begin
          errors++;
          $display("FAIL random_pix h=%0d v=%0d: got hit=%0d slot=%0d addr=%0d, expected hit=%0d slot=%0d addr=%0d",
                   h, v, pix_hit, pix_slot, pix_addr, exp_pix[20], exp_pix[19:17], exp_pix[16:0]);
        end
      end
    end
  endtask

  task automatic test_clear_and_async_reset();
    do_clear();
    run = 1'b1;
    repeat (201) do_tick(20);
    probe(680, 210);
    checks++;
    if (pix_hit !== 1'b1) begin
      errors++;
      $display("FAIL preclear_hit: got hit=%0d, expected 1", pix_hit);
    end
    clear = 1'b1;
    tick = 1'b1;
    rand_val = 7'd20;
    cyc();
    clear = 1'b0;
    tick = 1'b0;
    model_clear();
    checks++;
    if ({pix_hit, pix_slot, pix_addr, slot_en} !== 24'd0) begin
      errors++;
      $display("FAIL clear_beats_tick: got hit=%0d slot=%0d addr=%0d en=%b, expected all zero",
               pix_hit, pix_slot, pix_addr, slot_en);
    end
    repeat (201) do_tick(20);
    probe(680, 210);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({pix_hit, pix_slot, pix_addr, slot_en} !== 24'd0) begin
      errors++;
      $display("FAIL async_reset: got hit=%0d slot=%0d addr=%0d en=%b, expected all zero",
               pix_hit, pix_slot, pix_addr, slot_en);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    probe(680, 210);
    checks++;
    if (pix_hit !== 1'b0 || slot_en !== 3'b000) begin
      errors++;
      $display("FAIL after_reset: got hit=%0d en=%b, expected 0/000", pix_hit, slot_en);
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_scroll();
    test_skip();
    test_hit_and_freeze();
    test_overlap();
    test_random();
    test_clear_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
